pd_packet_serializer: RTL and testbench

PD_PACKET_SERIALIZER -- requirements
Module: pd_packet_serializer

---
 rtl/pd_pkg.sv | 7 +
 rtl/pd_down_counter.sv | 28 ++
 rtl/pd_packet_serializer.sv | 103 ++++++++++
 tb/tb_pd_packet_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// pd_pkg: shared types and constants for the packet serializer
//   state_e       : frame FSM states
//   SYNC_BYTE_DEF : default sync byte carried in the header word
package pd_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_STATUS, ST_PAYLOAD} state_e;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'h54;
endpackage

// File: rtl/pd_down_counter.sv
// pd_down_counter: loadable down counter with saturation at zero and a zero flag
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear to zero (highest priority after reset)
//   load_i   : load val_i
//   dec_i    : decrement by one, holds at zero
//   cnt_o    : current count
//   zero_o   : count equals zero
module pd_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pd_packet_serializer.sv
// pd_packet_serializer: serializes HEADER, STATUS and a payload block into a ready/valid word stream
//   clk, rst            : clock, synchronous active-high reset
//   payload             : frame payload, word PAYLOAD_WORDS-1 sent first
//   payload_valid/ready : load handshake for the payload
//   pid, pid_en         : packet id and its register load enable
//   status_flag/en      : status bit and its register load enable
//   flush               : abort the current frame and block loads
//   out_data/valid/ready: output word stream, out_last marks the final payload word
//   busy                : a frame is in progress
module pd_packet_serializer
   import pd_pkg::*;
#(
   parameter int         WORD_W        = 16,
   parameter int         PAYLOAD_WORDS = 18,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [PAYLOAD_WORDS-1:0][WORD_W-1:0] payload,
   input  logic                                 payload_valid,
   output logic                                 payload_ready,
   input  logic [7:0]                           pid,
   input  logic                                 pid_en,
   input  logic                                 status_flag,
   input  logic                                 status_en,
   input  logic                                 flush,
   output logic [WORD_W-1:0]                    out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_last,
   output logic                                 busy
);
   // keep the index at least one bit wide for single-word payloads
   localparam int CW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

   state_e                                 state_q, state_d;
   logic [7:0]                             pid_q, pid_snap_q;
   logic                                   status_q, status_snap_q;
   logic [PAYLOAD_WORDS-1:0][WORD_W-1:0]   payload_buf_q;
   logic [CW-1:0]                          idx;
   logic                                   idx_zero, last_beat, load;

   // end-of-frame beat: the only PAYLOAD cycle that may accept a new load
   assign last_beat     = (state_q == ST_PAYLOAD) && idx_zero && out_ready;
   assign payload_ready = !flush && ((state_q == ST_IDLE) || last_beat);
   assign load          = payload_valid && payload_ready;

   pd_down_counter #(.W(CW)) u_idx (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (flush),
      .load_i ((state_q == ST_STATUS) && out_ready),
      .val_i  (CW'(PAYLOAD_WORDS - 1)),
      .dec_i  ((state_q == ST_PAYLOAD) && out_ready),
      .cnt_o  (idx),
      .zero_o (idx_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    state_d = load ? ST_HEADER : ST_IDLE;
         ST_HEADER:  state_d = out_ready ? ST_STATUS : ST_HEADER;
         ST_STATUS:  state_d = out_ready ? ST_PAYLOAD : ST_STATUS;
         ST_PAYLOAD: state_d = !last_beat ? ST_PAYLOAD : load ? ST_HEADER : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_comb begin
      out_valid = (state_q != ST_IDLE);
      busy      = (state_q != ST_IDLE);
      out_last  = (state_q == ST_PAYLOAD) && idx_zero;
      out_data  = (state_q == ST_HEADER)  ? WORD_W'({SYNC_BYTE, pid_snap_q}) :
                  (state_q == ST_STATUS)  ? WORD_W'(status_snap_q) :
                  (state_q == ST_PAYLOAD) ? payload_buf_q[idx] : '0;
   end

   // snapshots capture the register values, so enables in the load cycle affect the next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         pid_q         <= '0;
         status_q      <= 1'b0;
         pid_snap_q    <= '0;
         status_snap_q <= 1'b0;
         payload_buf_q <= '0;
      end else begin
         if (pid_en)    pid_q    <= pid;
         if (status_en) status_q <= status_flag;
         if (load) begin
            pid_snap_q    <= pid_q;
            status_snap_q <= status_q;
            payload_buf_q <= payload;
         end
      end
   end
endmodule

// File: tb/tb_pd_packet_serializer.sv
// tb_pd_packet_serializer: directed self-checking bench for pd_packet_serializer
module tb_pd_packet_serializer;
   localparam int N = 18;

   typedef struct {
      logic [15:0] data;
      logic        last;
   } vec_t;

   logic                 clk = 0, rst = 1;
   logic [N-1:0][15:0]   payload = '0;
   logic                 payload_valid = 0, payload_ready;
   logic [7:0]           pid = 0;
   logic                 pid_en = 0, status_flag = 0, status_en = 0, flush = 0;
   logic [15:0]          out_data;
   logic                 out_valid, out_ready = 1, out_last, busy;

   logic [3:0][31:0]     s_payload = '0;
   logic                 s_pv = 0, s_pr;
   logic [7:0]           s_pid = 0;
   logic                 s_pid_en = 0;
   logic [31:0]          s_od;
   logic                 s_ov, s_ol, s_busy;

   int checks = 0, failures = 0;
   logic [15:0] got_d [64];
   logic        got_l [64];
   int nbeat, ncyc;

   always #5 clk = ~clk;

   pd_packet_serializer u_dut (
      .clk(clk), .rst(rst), .payload(payload), .payload_valid(payload_valid),
      .payload_ready(payload_ready), .pid(pid), .pid_en(pid_en),
      .status_flag(status_flag), .status_en(status_en), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );

   pd_packet_serializer #(.WORD_W(32), .PAYLOAD_WORDS(4)) u_small (
      .clk(clk), .rst(rst), .payload(s_payload), .payload_valid(s_pv),
      .payload_ready(s_pr), .pid(s_pid), .pid_en(s_pid_en),
      .status_flag(1'b0), .status_en(1'b0), .flush(1'b0),
      .out_data(s_od), .out_valid(s_ov), .out_ready(1'b1),
      .out_last(s_ol), .busy(s_busy)
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_payload(input logic [15:0] base);
      for (int i = 0; i < N; i++) payload[i] = base + 16'(i);
   endtask

   // drain one frame, recording accepted beats and checking outputs hold during stalls
   task automatic collect(input bit toggle);
      int cyc = 0, bad = 0;
      bit done = 0, pst = 0;
      logic [15:0] pd = '0;
      logic pl = 0;
      nbeat = 0;
      for (int i = 0; i < 64; i++) begin got_d[i] = '0; got_l[i] = 0; end
      while (!done && cyc < 200) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         #1;
         if (pst && (out_data !== pd || out_last !== pl || out_valid !== 1'b1)) bad++;
         pst = out_valid && !out_ready;
         pd  = out_data;
         pl  = out_last;
         if (out_valid && out_ready) begin
            if (nbeat < 64) begin got_d[nbeat] = out_data; got_l[nbeat] = out_last; end
            nbeat++;
            if (out_last) done = 1;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      out_ready = 1;
      ncyc = cyc;
      chk("stall_hold", bad, 0);
      chk("frame_done", done, 1);
   endtask

   task automatic expect_frame(input string n, input logic [7:0] p, input logic s, input logic [15:0] base);
      vec_t tbl [N+2];
      tbl[0] = '{{8'h54, p}, 1'b0};
      tbl[1] = '{{15'd0, s}, 1'b0};
      for (int k = 0; k < N; k++) tbl[2+k] = '{base + 16'(N-1-k), k == N-1};
      chk({n, "_beats"}, nbeat, N+2);
      for (int i = 0; i < N+2; i++) begin
         chk($sformatf("%s_data%0d", n, i), got_d[i], tbl[i].data);
         chk($sformatf("%s_last%0d", n, i), got_l[i], tbl[i].last);
      end
   endtask

   initial begin
      vec_t stbl [6];
      stbl[0] = '{16'h547E, 1'b0};
      // reset state
      step; step;
      rst = 0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", payload_ready, 1);

      // basic frame, out_ready always high
      pid = 8'hA5; pid_en = 1; status_flag = 1; status_en = 1;
      step;
      pid_en = 0; status_en = 0;
      set_payload(16'h1000);
      payload_valid = 1;
      #1 chk("idle_ready", payload_ready, 1);
      step;
      payload_valid = 0;
      chk("first_valid", out_valid, 1);
      collect(0);
      chk("min_cycles", ncyc, N+2);
      expect_frame("f1", 8'hA5, 1'b1, 16'h1000);
      chk("f1_idle_valid", out_valid, 0);
      chk("f1_idle_busy", busy, 0);

      // same frame with out_ready toggling
      payload_valid = 1;
      step;
      payload_valid = 0;
      collect(1);
      expect_frame("f2", 8'hA5, 1'b1, 16'h1000);

      // back-to-back: B waits while A runs; pid changes mid-frame
      payload_valid = 1;
      step;
      chk("a_busy_ready", payload_ready, 0);
      set_payload(16'h2000);
      pid = 8'h3C; pid_en = 1;
      collect(0);
      pid_en = 0;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_header", out_data, 16'h543C);
      chk("b2b_cycles", ncyc, N+2);
      expect_frame("fa", 8'hA5, 1'b1, 16'h1000);
      payload_valid = 0;
      collect(0);
      expect_frame("fb", 8'h3C, 1'b1, 16'h2000);

      // flush at payload index 9
      set_payload(16'h3000);
      payload_valid = 1;
      step;
      payload_valid = 0;
      for (int k = 0; k < 10; k++) step;
      chk("pre_flush_data", out_data, 16'h3009);
      flush = 1;
      #1 chk("flush_ready0", payload_ready, 0);
      step;
      chk("flush_valid", out_valid, 0);
      chk("flush_busy", busy, 0);
      flush = 0;
      #1 chk("post_flush_ready", payload_ready, 1);
      flush = 1; payload_valid = 1;
      #1 chk("flush_blocks_ready", payload_ready, 0);
      step;
      chk("flush_no_load", out_valid, 0);
      flush = 0;
      step;
      payload_valid = 0;
      chk("after_flush_hdr", out_data, 16'h543C);
      collect(0);
      expect_frame("fc", 8'h3C, 1'b1, 16'h3000);

      // reset mid-frame abandons the frame and clears pid/status
      payload_valid = 1;
      step;
      payload_valid = 0;
      step; step; step;
      rst = 1;
      step;
      rst = 0;
      chk("rstmid_valid", out_valid, 0);
      chk("rstmid_busy", busy, 0);
      for (int k = 0; k < 3; k++) begin
         step;
         chk($sformatf("rstmid_quiet%0d", k), out_valid, 0);
      end
      payload_valid = 1;
      step;
      payload_valid = 0;
      chk("rst_pid_hdr", out_data, 16'h5400);
      step;
      chk("rst_status", out_data, 16'h0000);
      flush = 1;
      step;
      flush = 0;

      // 32-bit, 4-word instance
      for (int i = 0; i < 4; i++) s_payload[i] = 32'hA000_0000 + i;
      stbl[1] = '{16'h0000, 1'b0};
      s_pid = 8'h7E; s_pid_en = 1;
      step;
      s_pid_en = 0; s_pv = 1;
      step;
      s_pv = 0;
      for (int k = 0; k < 6; k++) begin
         logic [31:0] e;
         e = (k == 0) ? 32'h0000_547E : (k == 1) ? 32'h0 : 32'hA000_0000 + 32'(5 - k);
         chk($sformatf("small_valid%0d", k), s_ov, 1);
         chk($sformatf("small_data%0d", k), s_od, e);
         chk($sformatf("small_last%0d", k), s_ol, k == 5);
         step;
      end
      chk("small_idle", s_ov, 0);
      chk("small_ready", s_pr, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
